tlp_header_router: RTL and testbench

TLP_HEADER_ROUTER -- requirements
Module: tlp_header_router

---
 rtl/tlp_header_router.sv | 155 +++++++++++++++
 tb/tb_tlp_header_router.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_header_router.sv
// tlp_header_router
//   Classifies an incoming request TLP header, builds the matching 96-bit
//   completion header and queues it with its payload in a small FIFO.
//   Unsupported requests are still queued. They carry an "unsupported request"
//   status and no destination, and they bump a saturating error counter.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : request handshake
//   in_header [127:0]        : request header, DW0 in bits [31:0]
//   in_payload [DATA_WIDTH]  : payload travelling with the header
//   out_valid/out_ready      : completion handshake (queue head)
//   out_header [95:0]        : generated completion header
//   out_payload [DATA_WIDTH] : payload, passed through unchanged
//   out_dest [2:0]           : 1 = cfg, 2 = mem, 3 = io, 0 = none
//   out_link [2:0]           : LINK_NUMBER[2:0]
//   level                    : queue occupancy
//   err_count [15:0]         : saturating count of unsupported requests
module tlp_header_router #(
  parameter int          LINK_NUMBER  = 0,
  parameter int          DATA_WIDTH   = 32,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] COMPLETER_ID = 16'hFFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [127:0]                  in_header,
  input  logic [DATA_WIDTH-1:0]         in_payload,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [95:0]                   out_header,
  output logic [DATA_WIDTH-1:0]         out_payload,
  output logic [2:0]                    out_dest,
  output logic [2:0]                    out_link,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [15:0]                   err_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [2:0]       LINK_BITS = 3'(LINK_NUMBER);

  typedef enum logic [2:0] {
    DEST_NONE = 3'd0,
    DEST_CFG  = 3'd1,
    DEST_MEM  = 3'd2,
    DEST_IO   = 3'd3
  } dest_e;

  logic [95:0]           hdr_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pay_mem  [FIFO_DEPTH];
  dest_e                 dest_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;
  logic             pop;

  logic [2:0]  fmt;
  logic [4:0]  typ;
  logic        is_mrd;
  logic        is_mwr;
  logic        is_io;
  logic        is_cfg;
  logic        supported;
  logic [95:0] new_hdr;
  dest_e       new_dest;

  // Reset is folded into the handshakes so that nothing is accepted or popped
  // in the reset cycle.
  assign in_ready  = !rst && (level < DEPTH_L);
  assign out_valid = !rst && (level != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_link  = LINK_BITS;

  // The head is masked so that an empty queue presents all-zero outputs.
  assign out_header  = out_valid ? hdr_mem[rd_ptr]  : '0;
  assign out_payload = out_valid ? pay_mem[rd_ptr]  : '0;
  assign out_dest    = out_valid ? dest_mem[rd_ptr] : DEST_NONE;

  // Completion header generation.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    fmt       = in_header[31:29];
    typ       = in_header[28:24];
    is_mrd    = (typ == 5'b00000) && (fmt[2:1] == 2'b00);
    is_mwr    = (typ == 5'b00000) && (fmt[2:1] == 2'b01);
    is_io     = (typ == 5'b00010);
    is_cfg    = (typ[4:1] == 4'b0010);
    supported = is_mrd || is_mwr || is_io || is_cfg;
    new_hdr   = '0;
    new_dest  = DEST_NONE;

    if (supported) begin
      new_hdr[9:0]   = in_header[9:0];
      new_hdr[28:12] = in_header[28:12];
      new_hdr[63:48] = COMPLETER_ID;
      new_hdr[79:72] = in_header[47:40];
      new_hdr[95:80] = in_header[63:48];
      if (is_mrd) begin
        new_hdr[31:29] = 3'b010;
        // A length field of 0 encodes 1024 DW, which is 4096 bytes.
        new_hdr[44:32] = (in_header[9:0] == 10'd0) ? 13'd4096
                                                   : {1'b0, in_header[9:0], 2'b00};
        // The lower address comes from DW2 for 3DW headers and from DW3 for
        // 4DW headers (fmt bit 0 set).
        new_hdr[70:64] = in_header[29] ? {in_header[102:98], 2'b00}
                                       : {in_header[70:66], 2'b00};
      end else begin
        new_hdr[44:32] = 13'd4;
      end
      new_dest = is_cfg ? DEST_CFG : (is_io ? DEST_IO : DEST_MEM);
    end else begin
      new_hdr[47:45] = 3'b001;
    end
  end

  // NOTE: the queue storage has no reset. Validity is tracked by the pointers
  // and the level, and the outputs are masked when the queue is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      hdr_mem[wr_ptr]  <= new_hdr;
      pay_mem[wr_ptr]  <= in_payload;
      dest_mem[wr_ptr] <= new_dest;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // update here sees the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      err_count <= '0;
    end else begin
      // The pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH.
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (accept && !supported && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tlp_header_router.sv
// Directed bench for tlp_header_router with the default parameters
// (DATA_WIDTH 32, FIFO_DEPTH 4, COMPLETER_ID FFFF, LINK_NUMBER 0).
module tb_tlp_header_router;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_header;
  logic [31:0]  in_payload;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  out_header;
  logic [31:0]  out_payload;
  logic [2:0]   out_dest;
  logic [2:0]   out_link;
  logic [2:0]   level;
  logic [15:0]  err_count;

  int passed = 0;
  int total  = 0;

  tlp_header_router dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_header  (in_header),
    .in_payload (in_payload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_header (out_header),
    .out_payload(out_payload),
    .out_dest   (out_dest),
    .out_link   (out_link),
    .level      (level),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Request headers: {DW3, DW2, DW1, DW0}.
  localparam logic [127:0] H_MRD  = {32'h0, 32'h0000_000C, 32'h1234_5A00, 32'h0000_0004};
  localparam logic [127:0] H_MRD0 = {32'h0000_007C, 32'h0000_0014, 32'h0, 32'h2000_0000};
  localparam logic [127:0] H_MWR  = {32'h0, 32'h0, 32'hABCD_1100, 32'h4000_0001};
  localparam logic [127:0] H_IO   = {32'h0, 32'h0, 32'h0000_2200, 32'h0200_0001};
  localparam logic [127:0] H_CFG  = {32'h0, 32'h0, 32'h5678_3300, 32'h4400_0001};
  localparam logic [127:0] H_UR   = {32'h0, 32'h0, 32'h9999_4400, 32'h1B00_0001};

  // Expected completion headers, computed by hand.
  localparam logic [95:0] C_MRD  = 96'h1234_5A0C_FFFF_0010_4000_0004;
  localparam logic [95:0] C_MRD0 = 96'h0000_007C_FFFF_1000_4000_0000;
  localparam logic [95:0] C_MWR  = 96'hABCD_1100_FFFF_0004_0000_0001;
  localparam logic [95:0] C_IO   = 96'h0000_2200_FFFF_0004_0200_0001;
  localparam logic [95:0] C_CFG  = 96'h5678_3300_FFFF_0004_0400_0001;
  localparam logic [95:0] C_UR   = 96'h0000_0000_0000_2000_0000_0000;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one request for a single cycle. The header is left on the bus
  // afterwards, which also shows that it is ignored once in_valid drops.
  task automatic push(input logic [127:0] h, input logic [31:0] p);
    in_valid   = 1'b1;
    in_header  = h;
    in_payload = p;
    tick();
    in_valid = 1'b0;
  endtask

  // Queues one request into an empty queue, checks the head, then pops it.
  task automatic one_shot(input string tag, input logic [127:0] h, input logic [31:0] p,
                          input logic [95:0] exp_hdr, input logic [2:0] exp_dest);
    out_ready = 1'b0;
    push(h, p);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_hdr"}, out_header, exp_hdr);
    check({tag, "_pay"}, out_payload, p);
    check({tag, "_dest"}, out_dest, exp_dest);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_empty"}, out_valid, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_header  = '0;
    in_payload = '0;
    out_ready  = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_header", out_header, 96'h0);
    check("rst_out_dest", out_dest, 3'd0);
    check("rst_err_count", err_count, 16'd0);
    check("out_link", out_link, 3'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1'b1);

    // An idle input with a non-zero header must be ignored.
    in_header = H_MRD;
    tick();
    check("idle_level", level, 3'd0);
    check("idle_out_valid", out_valid, 1'b0);

    // Memory read with one-cycle latency, and the head held under backpressure.
    push(H_MRD, 32'hDEAD_0001);
    check("mrd_valid", out_valid, 1'b1);
    check("mrd_hdr", out_header, C_MRD);
    check("mrd_dest", out_dest, 3'd2);
    check("mrd_level", level, 3'd1);
    tick();
    check("mrd_hold_hdr", out_header, C_MRD);
    check("mrd_hold_pay", out_payload, 32'hDEAD_0001);
    check("mrd_hold_dest", out_dest, 3'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mrd_pop_valid", out_valid, 1'b0);
    check("mrd_pop_hdr", out_header, 96'h0);
    check("mrd_pop_pay", out_payload, 32'h0);

    // The other supported classes.
    one_shot("mrd0", H_MRD0, 32'h0000_0044, C_MRD0, 3'd2);
    one_shot("mwr",  H_MWR,  32'h1111_2222, C_MWR,  3'd2);
    one_shot("io",   H_IO,   32'h3333_4444, C_IO,   3'd3);
    one_shot("cfg",  H_CFG,  32'h5555_6666, C_CFG,  3'd1);
    check("err_after_good", err_count, 16'd0);

    // Three unsupported requests.
    for (int i = 0; i < 3; i++) push(H_UR, 32'h0000_0A00 + 32'(i));
    check("ur_level", level, 3'd3);
    check("ur_err_count", err_count, 16'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ur_hdr", out_header, C_UR);
      check("ur_dest", out_dest, 3'd0);
      check("ur_pay", out_payload, 32'h0000_0A00 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("ur_drained", out_valid, 1'b0);

    // Fill past capacity, then drain in order.
    in_header = H_MWR;
    for (int i = 0; i < 5; i++) begin
      in_valid   = 1'b1;
      in_payload = 32'd100 + 32'(i);
      check("fill_in_ready", in_ready, (i < 4) ? 1'b1 : 1'b0);
      tick();
    end
    in_valid = 1'b0;
    check("full_level", level, 3'd4);
    check("full_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pay", out_payload, 32'd100 + 32'(i));
      check("drain_hdr", out_header, C_MWR);
      tick();
      if (i == 0) check("drain_in_ready", in_ready, 1'b1);
      check("drain_level", level, 3'(3 - i));
    end
    check("drain_empty", out_valid, 1'b0);
    out_ready = 1'b0;

    // Streaming at level 1: simultaneous accept and pop for 10 cycles.
    push(H_IO, 32'd200);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_payload = 32'd200 + 32'(i);
      check("stream_head", out_payload, 32'd200 + 32'(i - 1));
      tick();
      check("stream_level", level, 3'd1);
    end
    in_valid = 1'b0;
    check("stream_last", out_payload, 32'd210);
    tick();
    check("stream_empty", out_valid, 1'b0);
    out_ready = 1'b0;

    // Reset with three entries queued.
    push(H_MWR, 32'h0000_0301);
    push(H_UR,  32'h0000_0302);
    push(H_IO,  32'h0000_0303);
    check("pre_rst_level", level, 3'd3);
    check("pre_rst_err", err_count, 16'd4);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mid_rst_level", level, 3'd0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_err", err_count, 16'd0);
    check("mid_rst_hdr", out_header, 96'h0);
    rst       = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("post_rst_empty", out_valid, 1'b0);
    check("post_rst_level", level, 3'd0);
    push(H_CFG, 32'h0000_0077);
    check("post_rst_new_pay", out_payload, 32'h0000_0077);
    check("post_rst_new_hdr", out_header, C_CFG);
    check("post_rst_new_level", level, 3'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
